game_round_ctrl: RTL and testbench
==================================

// Module: game_round_ctrl
// PURPOSE
//  Parametrised round/score engine for the door-guessing game. It replaces the hard-wired
//  correct_door_*, p*_lives and time_up constants with live state for N players.
//  Sits between the player inputs and screen_drawer, in the 25 MHz VGA_CLK domain.
//  Pseudo-random correct doors, per-round countdown, life bookkeeping and game-over detect.
// PARAMETERS
//  NUM_PLAYERS  2           players, 1..4
//  NUM_DOORS    4           doors, power of two, 2..8; DOOR_W = $clog2(NUM_DOORS)
//  LIVES_INIT   3           starting lives, 1..7; LIFE_W = 3
//  TICK_DIV     25_000_000  clk cycles per countdown tick (1 s at 25 MHz)
//  ROUND_TICKS  10          ticks per round, 1..255; TIME_W = 8
//  REVEAL_TICKS 2           ticks that time_up is held high after round end
//  LFSR_SEED    16'hACE1    LFSR reset value; must be nonzero
// PORTS
//  clk          in   1                        clock (VGA_CLK)
//  reset        in   1                        asynchronous, active-low reset
//  start        in   1                        level; sampled in IDLE and GAME_OVER
//  player_pos   in   NUM_PLAYERS*DOOR_W       packed door choice; player i = [i*DOOR_W +: DOOR_W]
//  correct_door out  NUM_PLAYERS*DOOR_W       packed correct door per player
//  lives        out  NUM_PLAYERS*LIFE_W       packed remaining lives
//  time_left    out  TIME_W                   ticks remaining in the current round
//  time_up      out  1                        high during REVEAL
//  game_over    out  1                        high in GAME_OVER
//  alive_mask   out  NUM_PLAYERS              bit i = player i lives != 0
//  round_num    out  8                        rounds completed, saturates at 255
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; lives = LIVES_INIT for all players;
//   correct_door = 0; time_left = 0; time_up = 0; game_over = 0; round_num = 0;
//   alive_mask = all ones; lfsr = LFSR_SEED; tick counter = 0.
//  LFSR: 16-bit Galois, taps 16,14,13,11. Steps every clk in every state.
//   This ties the entropy to start timing.
//  Tick: counter counts 0..TICK_DIV-1 in ROUND and REVEAL only. tick pulses 1 cycle at wrap.
//   Counter clears on every state change.
//  FSM states:
//   IDLE      -> ROUND when start=1.
//   ROUND     entry cycle: correct_door[i] = lfsr[i*DOOR_W +: DOOR_W]; time_left = ROUND_TICKS.
//             Each tick decrements time_left. The tick that takes time_left 1->0 also moves to REVEAL.
//   REVEAL    entry cycle: sample player_pos once. For each alive player with pos != door,
//             lives-1 (never below 0). Dead players are untouched. round_num+1 (saturating).
//             time_up = 1 for REVEAL_TICKS ticks.
//             Exit to GAME_OVER if popcount(alive_mask) <= (NUM_PLAYERS>1 ? 1 : 0); else to ROUND.
//             The exit test uses the updated lives.
//   GAME_OVER game_over = 1; outputs hold. start=1 -> full re-init (as reset, except lfsr), then ROUND.
//  Latency: lives and alive_mask change 1 cycle after REVEAL entry.
//   time_up rises on the same edge that time_left reaches 0.
//  start is ignored in ROUND and REVEAL.
//  player_pos changes outside the REVEAL entry cycle have no effect.
//  Reset mid-round aborts immediately. No partial life update is retained.
// CONFIGURATION
//  GAME_SPEEDUP_EN defined:
//   each new round loads ROUND_TICKS - min(round_num, ROUND_TICKS-1) ticks, so the floor is 1 tick.
//  GAME_SPEEDUP_EN undefined:
//   every round loads ROUND_TICKS. round_num is still reported.
// TESTING (TICK_DIV=4, ROUND_TICKS=3, REVEAL_TICKS=2, NUM_PLAYERS=2, NUM_DOORS=4, LIVES_INIT=3)
//  1 Reset low mid-ROUND -> all outputs at reset values in the same cycle.
//    They stay there until start is asserted.
//  2 start pulse; both players set pos = correct_door
//    -> time_left 3,2,1,0 at 4-clk spacing; time_up high 8 clks; lives stay 3,3; round_num=1.
//  3 P0 wrong, P1 right for 3 rounds -> P0 lives 2,1,0; alive_mask=2'b10; game_over=1 after round 3.
//  4 Both wrong every round -> both reach 0 in the same REVEAL; game_over=1; alive_mask=0.
//  5 Toggle player_pos every cycle except the REVEAL entry cycle
//    -> only the entry-cycle value affects lives.
//  6 With GAME_SPEEDUP_EN: rounds 1..4 load time_left 3,2,1,1. Without it: 3,3,3,3.

Source files
------------

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round and score engine for the door-guessing game.
// It runs in the VGA_CLK domain and generates pseudo-random correct doors,
// a per-round countdown, per-player life tracking and game-over detection
// for NUM_PLAYERS players.
// Optional feature macro: GAME_SPEEDUP_EN. When it is defined, each new round
// is one tick shorter than the last, down to a floor of one tick.
module game_round_ctrl #(
  parameter int          NUM_PLAYERS  = 2,
  parameter int          NUM_DOORS    = 4,
  parameter int          LIVES_INIT   = 3,
  parameter int          TICK_DIV     = 25_000_000,
  parameter int          ROUND_TICKS  = 10,
  parameter int          REVEAL_TICKS = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         DOOR_W       = $clog2(NUM_DOORS),
  localparam int         LIFE_W       = 3,
  localparam int         TIME_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_PLAYERS*DOOR_W-1:0] player_pos,
  output logic [NUM_PLAYERS*DOOR_W-1:0] correct_door,
  output logic [NUM_PLAYERS*LIFE_W-1:0] lives,
  output logic [TIME_W-1:0]             time_left,
  output logic                          time_up,
  output logic                          game_over,
  output logic [NUM_PLAYERS-1:0]        alive_mask,
  output logic [7:0]                    round_num
);

  localparam int CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ALIVE_MIN = (NUM_PLAYERS > 1) ? 1 : 0;
  localparam logic [NUM_PLAYERS*LIFE_W-1:0] LIVES_ALL = {NUM_PLAYERS{LIFE_W'(LIVES_INIT)}};

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    REVEAL,
    GAME_OVER
  } state_t;

  state_t                        state;
  logic [15:0]                   lfsr;
  logic [CNT_W-1:0]              tick_cnt;
  logic [7:0]                    reveal_cnt;
  logic                          reveal_entry;
  logic                          tick;
  logic [NUM_PLAYERS*LIFE_W-1:0] lives_upd;
  logic [NUM_PLAYERS-1:0]        alive_upd;
  logic [NUM_PLAYERS-1:0]        alive_eff;
  logic                          game_end;
  logic [7:0]                    round_inc;
  logic [TIME_W-1:0]             load_ticks;
  logic [NUM_PLAYERS*DOOR_W-1:0] door_pick;

  // The low bits of the LFSR supply the doors: player i gets lfsr[i*DOOR_W +: DOOR_W]
  assign door_pick = lfsr[NUM_PLAYERS*DOOR_W-1:0];

  // The Galois LFSR (taps 16,14,13,11) free-runs every cycle, so the doors depend on when start arrives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Tick strobe, reveal-time life update, and the end-of-game test that uses the updated lives
  always_comb begin
    tick = 1'b0;
    if ((state == ROUND || state == REVEAL) && tick_cnt == CNT_W'(TICK_DIV - 1)) begin
      tick = 1'b1;
    end
    lives_upd = lives;
    alive_upd = alive_mask;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (lives[i*LIFE_W +: LIFE_W] != '0 &&
          player_pos[i*DOOR_W +: DOOR_W] != correct_door[i*DOOR_W +: DOOR_W]) begin
        lives_upd[i*LIFE_W +: LIFE_W] = lives[i*LIFE_W +: LIFE_W] - LIFE_W'(1);
      end
      alive_upd[i] = (lives_upd[i*LIFE_W +: LIFE_W] != '0);
    end
    alive_eff = reveal_entry ? alive_upd : alive_mask;
    game_end  = ($countones(alive_eff) <= ALIVE_MIN);
    round_inc = (round_num == 8'hFF) ? round_num : round_num + 8'd1;
  end

`ifdef GAME_SPEEDUP_EN
  logic [7:0] round_eff;

  // The countdown shrinks by one tick per completed round, with a floor of one tick
  always_comb begin
    round_eff = reveal_entry ? round_inc : round_num;
    if (round_eff >= 8'(ROUND_TICKS - 1)) begin
      load_ticks = TIME_W'(1);
    end else begin
      load_ticks = TIME_W'(ROUND_TICKS) - round_eff;
    end
  end
`else
  assign load_ticks = TIME_W'(ROUND_TICKS);
`endif

  // Round sequencing FSM with registered outputs; the tick counter restarts on every state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      reveal_cnt   <= '0;
      reveal_entry <= 1'b0;
      correct_door <= '0;
      lives        <= LIVES_ALL;
      time_left    <= '0;
      time_up      <= 1'b0;
      game_over    <= 1'b0;
      alive_mask   <= '1;
      round_num    <= '0;
    end else begin
      reveal_entry <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= ROUND;
            tick_cnt     <= '0;
            correct_door <= door_pick;
            time_left    <= TIME_W'(ROUND_TICKS);
          end
        end
        ROUND: begin
          if (tick) begin
            tick_cnt <= '0;
            if (time_left <= TIME_W'(1)) begin
              state        <= REVEAL;
              time_left    <= '0;
              time_up      <= 1'b1;
              reveal_cnt   <= '0;
              reveal_entry <= 1'b1;
            end else begin
              time_left <= time_left - TIME_W'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end
        REVEAL: begin
          if (reveal_entry) begin
            lives      <= lives_upd;
            alive_mask <= alive_upd;
            round_num  <= round_inc;
          end
          if (tick) begin
            tick_cnt <= '0;
            if (reveal_cnt == 8'(REVEAL_TICKS - 1)) begin
              time_up <= 1'b0;
              if (game_end) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state        <= ROUND;
                correct_door <= door_pick;
                time_left    <= load_ticks;
              end
            end else begin
              reveal_cnt <= reveal_cnt + 8'd1;
            end
          end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
          end
        end
        GAME_OVER: begin
          if (start) begin
            state        <= ROUND;
            tick_cnt     <= '0;
            reveal_cnt   <= '0;
            lives        <= LIVES_ALL;
            alive_mask   <= '1;
            round_num    <= '0;
            game_over    <= 1'b0;
            time_up      <= 1'b0;
            correct_door <= door_pick;
            time_left    <= TIME_W'(ROUND_TICKS);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed self-checking bench for game_round_ctrl.
// It predicts the correct doors and the expected round results with a
// reference model. The expected results go into a scoreboard queue when the
// guesses are driven, and are checked when the DUT updates its lives.
module tb_game_round_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int ROUND_TICKS  = 3;
  localparam int REVEAL_TICKS = 2;

  typedef struct {
    logic [5:0] lives;
    logic [1:0] alive;
    logic [7:0] round;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] player_pos;
  logic [3:0] correct_door;
  logic [5:0] lives;
  logic [7:0] time_left;
  logic       time_up;
  logic       game_over;
  logic [1:0] alive_mask;
  logic [7:0] round_num;

  logic [15:0] m_lfsr;
  logic [15:0] m_prev;
  logic [5:0]  model_lives;
  logic [1:0]  model_alive;
  logic [7:0]  model_round;
  logic        model_end;
  exp_t        sb[$];
  int          checks;
  int          errors;

  game_round_ctrl #(
    .NUM_PLAYERS (2),
    .NUM_DOORS   (4),
    .LIVES_INIT  (3),
    .TICK_DIV    (TICK_DIV),
    .ROUND_TICKS (ROUND_TICKS),
    .REVEAL_TICKS(REVEAL_TICKS),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .player_pos  (player_pos),
    .correct_door(correct_door),
    .lives       (lives),
    .time_left   (time_left),
    .time_up     (time_up),
    .game_over   (game_over),
    .alive_mask  (alive_mask),
    .round_num   (round_num)
  );

  // 25 MHz-style free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR; m_prev holds the value seen just before the most recent edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  task automatic applyStimulus(input logic start_v, input logic [3:0] pos_v);
    start      = start_v;
    player_pos = pos_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_lives"}, 32'(lives), 32'h1B);
    checkOutput({tag, "_alive"}, 32'(alive_mask), 32'h3);
    checkOutput({tag, "_door"}, 32'(correct_door), 32'h0);
    checkOutput({tag, "_time_left"}, 32'(time_left), 32'h0);
    checkOutput({tag, "_time_up"}, 32'(time_up), 32'h0);
    checkOutput({tag, "_game_over"}, 32'(game_over), 32'h0);
    checkOutput({tag, "_round"}, 32'(round_num), 32'h0);
  endtask

  // One full round starting from the first ROUND cycle; returns on the last REVEAL cycle
  task automatic playRound(input bit right0, input bit right1, input bit toggle);
    logic [3:0] door;
    logic [3:0] want;
    logic [1:0] rights;
    int         load;
    int         reveal_at;
    exp_t       e;
    exp_t       got;
`ifdef GAME_SPEEDUP_EN
    load = ROUND_TICKS - ((int'(model_round) < ROUND_TICKS - 1) ? int'(model_round) : ROUND_TICKS - 1);
`else
    load = ROUND_TICKS;
`endif
    reveal_at = TICK_DIV * load;
    rights    = {right1, right0};
    @(negedge clk);
    applyStimulus(1'b0, player_pos);
    door = m_prev[3:0];
    checkOutput("correct_door", 32'(correct_door), 32'(door));
    checkOutput("lives_at_round_start", 32'(lives), 32'(model_lives));
    checkOutput("game_over_in_round", 32'(game_over), 32'h0);
    want[1:0] = right0 ? door[1:0] : door[1:0] ^ 2'b01;
    want[3:2] = right1 ? door[3:2] : door[3:2] ^ 2'b01;
    for (int n = 0; n < reveal_at + TICK_DIV * REVEAL_TICKS; n++) begin
      if (n > 0) @(negedge clk);
      checkOutput("time_left", 32'(time_left), (n < reveal_at) ? load - n / TICK_DIV : 0);
      checkOutput("time_up", 32'(time_up), (n >= reveal_at) ? 1 : 0);
      if (toggle && n != reveal_at) begin
        applyStimulus(1'b0, want ^ ((n % 2 == 1) ? 4'b1111 : 4'b0101));
      end else begin
        applyStimulus(1'b0, want);
      end
      if (n == reveal_at) begin
        for (int p = 0; p < 2; p++) begin
          if (model_lives[p*3 +: 3] != 3'd0 && !rights[p]) begin
            model_lives[p*3 +: 3] = model_lives[p*3 +: 3] - 3'd1;
          end
          model_alive[p] = (model_lives[p*3 +: 3] != 3'd0);
        end
        model_round = (model_round == 8'hFF) ? model_round : model_round + 8'd1;
        model_end   = ($countones(model_alive) <= 1);
        e.lives = model_lives;
        e.alive = model_alive;
        e.round = model_round;
        sb.push_back(e);
      end
      if (n == reveal_at + 1) begin
        checkOutput("scoreboard_not_empty", 32'(sb.size()), 32'h1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          checkOutput("lives_after_reveal", 32'(lives), 32'(got.lives));
          checkOutput("alive_after_reveal", 32'(alive_mask), 32'(got.alive));
          checkOutput("round_after_reveal", 32'(round_num), 32'(got.round));
        end
      end
    end
  endtask

  task automatic finishGame();
    @(negedge clk);
    checkOutput("game_over_set", 32'(game_over), 32'(model_end));
    checkOutput("time_up_cleared", 32'(time_up), 32'h0);
    checkOutput("alive_final", 32'(alive_mask), 32'(model_alive));
    checkOutput("lives_final", 32'(lives), 32'(model_lives));
    repeat (5) @(negedge clk);
    checkOutput("game_over_hold", 32'(game_over), 32'h1);
    checkOutput("lives_hold", 32'(lives), 32'(model_lives));
    checkOutput("time_left_hold", 32'(time_left), 32'h0);
    checkOutput("round_hold", 32'(round_num), 32'(model_round));
  endtask

  task automatic restartModel();
    model_lives = 6'o33;
    model_alive = 2'b11;
    model_round = 8'd0;
    model_end   = 1'b0;
  endtask

  // Directed scenario sequence
  initial begin
    logic [3:0] door;
    checks = 0;
    errors = 0;
    restartModel();
    reset = 1'b0;
    applyStimulus(1'b0, 4'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues("por");

    $display("[TB] reset in the middle of a game");
    applyStimulus(1'b1, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 4'h0);
    door = m_prev[3:0];
    checkOutput("abort_door", 32'(correct_door), 32'(door));
    applyStimulus(1'b0, door ^ 4'b0101);
    for (int k = 0; k < 100 && time_up !== 1'b1; k++) @(negedge clk);
    checkOutput("abort_reveal_reached", 32'(time_up), 32'h1);
    repeat (2) @(negedge clk);
    checkOutput("abort_lives_partial", 32'(lives), 32'h12);
    #2 reset = 1'b0;
    #1;
    checkResetValues("async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 4'h0);
    repeat (6) @(negedge clk);
    checkResetValues("idle_hold");
    restartModel();

    $display("[TB] both players correct, then P0 wrong for three rounds");
    applyStimulus(1'b1, 4'h0);
    playRound(1'b1, 1'b1, 1'b0);
    playRound(1'b0, 1'b1, 1'b0);
    playRound(1'b0, 1'b1, 1'b0);
    playRound(1'b0, 1'b1, 1'b0);
    finishGame();

    $display("[TB] restart, toggling guesses, then both wrong until out");
    applyStimulus(1'b1, 4'h0);
    restartModel();
    playRound(1'b1, 1'b0, 1'b1);
    playRound(1'b0, 1'b1, 1'b1);
    playRound(1'b0, 1'b0, 1'b0);
    playRound(1'b0, 1'b0, 1'b0);
    finishGame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
